// File: rtl/flags_cond_pkg.sv
// rtl/flags_cond_pkg.sv - condition-code and flag bit-index constants shared by ALU, decoder and branch logic
package flags_cond_pkg;

  localparam int FLAG_W = 4;
  localparam int COND_W = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  localparam logic [COND_W-1:0] COND_EQ = 4'h0;
  localparam logic [COND_W-1:0] COND_NE = 4'h1;
  localparam logic [COND_W-1:0] COND_CS = 4'h2;
  localparam logic [COND_W-1:0] COND_CC = 4'h3;
  localparam logic [COND_W-1:0] COND_MI = 4'h4;
  localparam logic [COND_W-1:0] COND_PL = 4'h5;
  localparam logic [COND_W-1:0] COND_VS = 4'h6;
  localparam logic [COND_W-1:0] COND_VC = 4'h7;
  localparam logic [COND_W-1:0] COND_HI = 4'h8;
  localparam logic [COND_W-1:0] COND_LS = 4'h9;
  localparam logic [COND_W-1:0] COND_GE = 4'hA;
  localparam logic [COND_W-1:0] COND_LT = 4'hB;
  localparam logic [COND_W-1:0] COND_GT = 4'hC;
  localparam logic [COND_W-1:0] COND_LE = 4'hD;
  localparam logic [COND_W-1:0] COND_AL = 4'hE;
  localparam logic [COND_W-1:0] COND_NV = 4'hF;

endpackage

// File: rtl/flags_cond_unit_cond_eval.sv
// rtl/flags_cond_unit_cond_eval.sv - combinational branch-condition evaluator over an N,Z,V,C flag word
module cond_eval
  import flags_cond_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              take_comb
);

  logic n, z, v, c;

  always_comb begin
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    v = flags[FLAG_V];
    c = flags[FLAG_C];
    take_comb = 1'b0;
    case (cond)
      COND_EQ: take_comb = z;
      COND_NE: take_comb = !z;
      COND_CS: take_comb = c;
      COND_CC: take_comb = !c;
      COND_MI: take_comb = n;
      COND_PL: take_comb = !n;
      COND_VS: take_comb = v;
      COND_VC: take_comb = !v;
      COND_HI: take_comb = c & !z;
      COND_LS: take_comb = !c | z;
      COND_GE: take_comb = (n == v);
      COND_LT: take_comb = (n != v);
      COND_GT: take_comb = !z & (n == v);
      COND_LE: take_comb = z | (n != v);
      COND_AL: take_comb = 1'b1;
      COND_NV: take_comb = 1'b0;
      default: take_comb = 1'b0;
    endcase
  end

endmodule

// File: rtl/flags_cond_unit.sv
// rtl/flags_cond_unit.sv - status register, flag save stack and one-stage condition evaluation pipeline
module flags_cond_unit
  import flags_cond_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  localparam int PTR_W = $clog2(STACK_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLAG_W-1:0] flags_n_z_v_c,
  input  logic              flags_we,
  input  logic [COND_W-1:0] cond,
  input  logic              cond_valid,
  output logic              cond_ready,
  output logic              take,
  output logic              take_valid,
  input  logic              take_ready,
  input  logic              push,
  input  logic              pop,
  output logic [FLAG_W-1:0] flags_q,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  localparam int IDX_W = PTR_W - 1;

  logic [FLAG_W-1:0] flags_d;
  logic [PTR_W-1:0]  occ_q, occ_d;
  logic [FLAG_W-1:0] stack_q [STACK_DEPTH];
  logic [FLAG_W-1:0] stack_d [STACK_DEPTH];
  logic              err_q, err_d;
  logic              take_q, take_d;
  logic              take_valid_q, take_valid_d;

  logic              push_ok, pop_ok, accept, take_comb;
  logic [PTR_W-1:0]  rd_ptr;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [FLAG_W-1:0] eval_flags;

  assign stack_full  = (occ_q == PTR_W'(STACK_DEPTH));
  assign stack_empty = (occ_q == '0);
  assign rd_ptr      = occ_q - PTR_W'(1);
  assign wr_idx      = occ_q[IDX_W-1:0];
  assign rd_idx      = rd_ptr[IDX_W-1:0];

  assign cond_ready  = !take_valid_q | take_ready;
  assign accept      = cond_valid & cond_ready;
  // Freshly written ALU flags are bypassed; pop-restored flags are not.
  assign eval_flags  = flags_we ? flags_n_z_v_c : flags_q;

  cond_eval u_cond_eval (
    .cond      (cond),
    .flags     (eval_flags),
    .take_comb (take_comb)
  );

  always_comb begin
    push_ok = push & !pop & !stack_full;
    pop_ok  = pop & !push & !stack_empty;

    err_d = err_q | (push & pop) | (push & !pop & stack_full) | (pop & !push & stack_empty);

    stack_d = stack_q;
    if (push_ok) stack_d[wr_idx] = flags_q;

    occ_d = occ_q;
    if (push_ok)     occ_d = occ_q + PTR_W'(1);
    else if (pop_ok) occ_d = rd_ptr;

    // A pop coinciding with flags_we still retires the stack entry.
    if (flags_we)    flags_d = flags_n_z_v_c;
    else if (pop_ok) flags_d = stack_q[rd_idx];
    else             flags_d = flags_q;

    take_d       = take_q;
    take_valid_d = take_valid_q;
    if (accept) begin
      take_d       = take_comb;
      take_valid_d = 1'b1;
    end else if (take_ready) begin
      take_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q      <= '0;
      occ_q        <= '0;
      err_q        <= 1'b0;
      take_q       <= 1'b0;
      take_valid_q <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      occ_q        <= occ_d;
      err_q        <= err_d;
      take_q       <= take_d;
      take_valid_q <= take_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign take       = take_q;
  assign take_valid = take_valid_q;
  assign stack_err  = err_q;

endmodule

// File: doc/flags_cond_unit.md
Name: flags_cond_unit

Overview:
- Consumer end of the ALU status interface.
- Latches the 4-bit flags_n_z_v_c word that the ALU ops (AND/OR/XOR/ADD/…) produce into a status register.
- Evaluates 4-bit branch condition codes against that register through a one-stage valid/ready pipeline.
- Holds a small flag save stack (push/pop) for call/interrupt context. Sits between the ALU and the branch/PC logic.

Parameters:
- STACK_DEPTH, 4, number of saved flag words (power of 2, >=2)
- PTR_W, $clog2(STACK_DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- flags_n_z_v_c  input  4  ALU flags: [3]=N, [2]=Z, [1]=V, [0]=C
- flags_we  input  1  load flags_n_z_v_c into status register
- cond  input  4  condition code to evaluate
- cond_valid  input  1  cond request valid
- cond_ready  output  1  unit can accept a request this cycle
- take  output  1  condition result (1 = branch taken)
- take_valid  output  1  take is valid
- take_ready  input  1  downstream consumes take
- push  input  1  save current status register onto stack
- pop  input  1  restore status register from stack top
- flags_q  output  4  current status register
- stack_full  output  1  occupancy == STACK_DEPTH
- stack_empty  output  1  occupancy == 0
- stack_err  output  1  sticky overflow/underflow/conflict flag

Behaviour:
- Reset (rst=1 at clk edge): flags_q=0000, take=0, take_valid=0, occupancy=0, stack_empty=1, stack_full=0, stack_err=0. Stack contents don't-care. Reset mid-transaction discards any pending take.
- Status register priority per cycle: flags_we > pop > hold.
  - With flags_we=1, the register loads flags_n_z_v_c. A simultaneous pop still decrements the pointer, but its data is discarded.
- Push writes the pre-update flags_q to stack[occupancy] and increments occupancy. The new flags_q (if flags_we) is not what is saved.
- Pop, non-empty and no flags_we: flags_q <= stack[occupancy-1], occupancy decrements.
- Push when full: no write, occupancy unchanged, stack_err<=1.
- Pop when empty: no change, stack_err<=1.
- Push and pop in the same cycle: no stack change, flags_q unchanged unless flags_we, stack_err<=1.
- stack_err clears only on rst.
- stack_full and stack_empty are combinational from the registered occupancy.
- Handshake:
  - cond_ready = !take_valid | take_ready.
  - Transfer occurs when cond_valid & cond_ready.
  - take/take_valid are registered; latency is 1 cycle from acceptance.
  - While take_valid & !take_ready, take holds stable and no new request is accepted.
  - Back-to-back acceptance is allowed when take_ready=1, giving 1 result per cycle.
  - With no accepted request and take_ready=1, take_valid<=0.
- Flag bypass: the evaluation operand is flags_n_z_v_c when flags_we=1 in the accepting cycle, else flags_q. Pop-restored flags are not bypassed; they are visible from the next cycle.
- Condition table (f = N,Z,V,C):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F NV: 0

Decomposition:
- Shared package: condition-code localparams (COND_EQ…COND_NV) and flag bit-index constants (FLAG_N=3, FLAG_Z=2, FLAG_V=1, FLAG_C=0), reused by the ALU and decoder.
- One combinational sub-module, cond_eval: inputs cond[3:0] and flags[3:0], output take_comb.
- Top module contains the status register, stack, and handshake stage.

Test Plan:
- Reset, then flags_we=1 with flags=0100, the same cycle cond=0 (EQ) and cond_valid=1, take_ready=1 -> next cycle take_valid=1, take=1 (bypass). Then cond=1 (NE) -> take=0.
- flags_q=1000 (N=1, V=0): issue GE, LT, GT, LE back-to-back with take_ready=1 -> takes 0,1,0,1 on consecutive cycles, take_valid continuously 1.
- take_ready=0 for 3 cycles after an accepted HI with flags=0001 -> take=1 held, cond_ready=0 throughout; raise take_ready -> consumed, next request accepted the same cycle.
- Sequence:
  - flags 0001, push; flags 0110, push; flags 1000, pop -> flags_q=0110
  - pop -> flags_q=0001, stack_empty=1
  - pop again -> stack_err=1, flags_q stays 0001
- Push 4 times with distinct flags (STACK_DEPTH=4) -> stack_full=1. A 5th push sets stack_err and leaves contents intact. 4 pops restore in LIFO order.
- push & pop together with occupancy 2 -> occupancy stays 2, stack_err=1. Assert rst mid-pending take (take_valid=1, take_ready=0) -> take_valid=0, flags_q=0000, stack_empty=1 next cycle.
